// File: rtl/wid_width_serializer.sv
// Wide-to-narrow serializer: holds one WIDTH*MULTIPLIER word and emits it as
// MULTIPLIER registered narrow beats, with valid/ready handshakes on both sides.
module wid_width_serializer #(
    parameter int  WIDTH      = 8,
    parameter int  MULTIPLIER = 2,
    parameter bit  LSB_FIRST  = 1'b1,
    localparam int IDXW       = (MULTIPLIER > 1) ? $clog2(MULTIPLIER) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [WIDTH*MULTIPLIER-1:0] s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WIDTH-1:0]            m_data,
    output logic                        m_last,
    output logic [IDXW-1:0]             beat_idx
);

    localparam int WW = WIDTH * MULTIPLIER;

    if (WIDTH < 1 || MULTIPLIER < 1) begin : g_param_check
        $error("wid_width_serializer: WIDTH and MULTIPLIER must both be >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e            state_q;
    logic [WW-1:0]     hold_q;
    logic [IDXW-1:0]   beat_idx_q;
    logic [WIDTH-1:0]  m_data_q;
    logic              m_valid_q;
    logic              m_last_q;

    logic              accept_s;
    logic              beat_xfer_s;
    logic [IDXW-1:0]   beat_idx_d;

    // Beat idx of a word; MSB-first order walks the slices from the top down.
    function automatic logic [WIDTH-1:0] slice_of(input logic [WW-1:0]   word,
                                                  input logic [IDXW-1:0] idx);
        int unsigned k;
        k = LSB_FIRST ? 32'(idx) : (32'(MULTIPLIER - 1) - 32'(idx));
        return WIDTH'(word >> (k * 32'(WIDTH)));
    endfunction

    // Upstream handshake and beat-advance decode.
    always_comb begin
        s_ready     = (state_q == ST_IDLE) || (m_valid_q && m_ready && m_last_q);
        accept_s    = s_valid && s_ready;
        beat_xfer_s = m_valid_q && m_ready;
        beat_idx_d  = beat_idx_q + IDXW'(1);
    end

    // Serializer state machine with registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            beat_idx_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else if (accept_s) begin
            // A new word may land on the same edge as the previous last beat.
            state_q    <= ST_SEND;
            hold_q     <= s_data;
            beat_idx_q <= '0;
            m_data_q   <= slice_of(s_data, '0);
            m_valid_q  <= 1'b1;
            m_last_q   <= (MULTIPLIER == 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_SEND: begin
                    if (beat_xfer_s && m_last_q) begin
                        state_q    <= ST_IDLE;
                        m_valid_q  <= 1'b0;
                        m_last_q   <= 1'b0;
                        beat_idx_q <= '0;
                    end else if (beat_xfer_s) begin
                        beat_idx_q <= beat_idx_d;
                        m_data_q   <= slice_of(hold_q, beat_idx_d);
                        m_last_q   <= (beat_idx_d == IDXW'(MULTIPLIER - 1));
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    m_valid_q  <= 1'b0;
                    m_last_q   <= 1'b0;
                    beat_idx_q <= '0;
                end
            endcase
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign beat_idx = beat_idx_q;

endmodule

// File: tb/tb_wid_width_serializer.sv
// Bench for wid_width_serializer: four configurations driven by directed
// scenarios plus a randomized run scored against a beat-queue reference model.
module tb_wid_width_serializer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // A: 8x2 LSB-first, B: 8x2 MSB-first, C: 4x4 LSB-first, D: 8x1.
    logic       a_sv, a_sr, a_mv, a_mr, a_ml, a_bi;
    logic [15:0] a_sd;
    logic [7:0]  a_md;
    logic       b_sv, b_sr, b_mv, b_mr, b_ml, b_bi;
    logic [15:0] b_sd;
    logic [7:0]  b_md;
    logic       c_sv, c_sr, c_mv, c_mr, c_ml;
    logic [1:0]  c_bi;
    logic [15:0] c_sd;
    logic [3:0]  c_md;
    logic       d_sv, d_sr, d_mv, d_mr, d_ml, d_bi;
    logic [7:0]  d_sd;
    logic [7:0]  d_md;

    wid_width_serializer #(.WIDTH(8), .MULTIPLIER(2), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md), .m_last(a_ml), .beat_idx(a_bi));
    wid_width_serializer #(.WIDTH(8), .MULTIPLIER(2), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .m_last(b_ml), .beat_idx(b_bi));
    wid_width_serializer #(.WIDTH(4), .MULTIPLIER(4), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .s_valid(c_sv), .s_ready(c_sr), .s_data(c_sd),
        .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md), .m_last(c_ml), .beat_idx(c_bi));
    wid_width_serializer #(.WIDTH(8), .MULTIPLIER(1), .LSB_FIRST(1'b1)) u_d (
        .clk(clk), .rst(rst), .s_valid(d_sv), .s_ready(d_sr), .s_data(d_sd),
        .m_valid(d_mv), .m_ready(d_mr), .m_data(d_md), .m_last(d_ml), .beat_idx(d_bi));

    // Reference: nibble k of a 16-bit word for the 4x4 LSB-first configuration.
    function automatic int nib(input int word, input int k);
        return (word >> (4 * k)) & 'hF;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++; if (a_sr !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", a_sr); end
        total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", a_mv); end
        total++; if (a_md !== 8'h00) begin bad++; $display("FAIL rst_m_data got=%h exp=00", a_md); end
        total++; if (a_ml !== 1'b0 || a_bi !== 1'b0) begin bad++; $display("FAIL rst_last_idx got=%b%b exp=00", a_ml, a_bi); end
        total++; if (c_mv !== 1'b0 || c_bi !== 2'd0) begin bad++; $display("FAIL rst_c_state got=%b/%0d exp=0/0", c_mv, c_bi); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (a_sr !== 1'b1 || a_mv !== 1'b0) begin bad++; $display("FAIL post_rst got=%b/%b exp=1/0", a_sr, a_mv); end
    endtask

    task automatic test_lsb_first();
        a_sv = 1'b1; a_sd = 16'hA55A; a_mr = 1'b1;
        @(negedge clk);
        a_sv = 1'b0; a_sd = 'x;
        total++; if (a_mv !== 1'b1 || a_md !== 8'h5A) begin bad++; $display("FAIL lsb_beat0 got=%b/%h exp=1/5a", a_mv, a_md); end
        total++; if (a_ml !== 1'b0 || a_bi !== 1'b0) begin bad++; $display("FAIL lsb_beat0_last_idx got=%b/%b exp=0/0", a_ml, a_bi); end
        @(negedge clk);
        total++; if (a_mv !== 1'b1 || a_md !== 8'hA5) begin bad++; $display("FAIL lsb_beat1 got=%b/%h exp=1/a5", a_mv, a_md); end
        total++; if (a_ml !== 1'b1 || a_bi !== 1'b1) begin bad++; $display("FAIL lsb_beat1_last_idx got=%b/%b exp=1/1", a_ml, a_bi); end
        @(negedge clk);
        total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL lsb_drop got=%b exp=0", a_mv); end
    endtask

    task automatic test_msb_first();
        b_sv = 1'b1; b_sd = 16'hA55A; b_mr = 1'b1;
        @(negedge clk);
        b_sv = 1'b0;
        total++; if (b_md !== 8'hA5 || b_ml !== 1'b0) begin bad++; $display("FAIL msb_beat0 got=%h/%b exp=a5/0", b_md, b_ml); end
        @(negedge clk);
        total++; if (b_md !== 8'h5A || b_ml !== 1'b1) begin bad++; $display("FAIL msb_beat1 got=%h/%b exp=5a/1", b_md, b_ml); end
        @(negedge clk);
        total++; if (b_mv !== 1'b0) begin bad++; $display("FAIL msb_drop got=%b exp=0", b_mv); end
    endtask

    task automatic test_back_to_back();
        int exp_beats[8];
        for (int k = 0; k < 4; k++) begin
            exp_beats[k]     = nib('h1234, k);
            exp_beats[k + 4] = nib('hABCD, k);
        end
        c_mr = 1'b1; c_sv = 1'b1; c_sd = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) c_sd = 16'hABCD;
            if (i == 4) c_sv = 1'b0;
            #1;
            total++; if (c_mv !== 1'b1 || c_md !== 4'(exp_beats[i])) begin bad++; $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", i, c_mv, c_md, exp_beats[i]); end
            total++; if (c_sr !== ((i % 4) == 3)) begin bad++; $display("FAIL b2b_s_ready%0d got=%b exp=%b", i, c_sr, (i % 4) == 3); end
        end
        @(negedge clk);
        total++; if (c_mv !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", c_mv); end
    endtask

    task automatic test_stall();
        int n = 0;
        c_sv = 1'b1; c_sd = 16'h1234; c_mr = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            c_sv = 1'b0;
            c_mr = ((cyc % 2) == 0);
            #1;
            total++; if (c_mv !== 1'b1 || c_md !== 4'(nib('h1234, n))) begin bad++; $display("FAIL stall_data cyc%0d got=%b/%h exp=1/%h", cyc, c_mv, c_md, nib('h1234, n)); end
            total++; if (c_bi !== 2'(n) || c_ml !== (n == 3)) begin bad++; $display("FAIL stall_idx cyc%0d got=%0d/%b exp=%0d/%b", cyc, c_bi, c_ml, n, n == 3); end
            total++; if (c_sr !== (n == 3 && c_mr)) begin bad++; $display("FAIL stall_s_ready cyc%0d got=%b exp=%b", cyc, c_sr, n == 3 && c_mr); end
            if (c_mr) n++;
            if (n == 4) break;
        end
        @(negedge clk);
        c_mr = 1'b1;
        total++; if (c_mv !== 1'b0) begin bad++; $display("FAIL stall_drop got=%b exp=0", c_mv); end
    endtask

    task automatic test_random();
        int  q[$];
        bit  exp_v, exp_sr;
        int  w;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            exp_v = (q.size() != 0);
            total++; if (c_mv !== exp_v) begin bad++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", cyc, c_mv, exp_v); end
            if (exp_v) begin
                total++; if (c_md !== 4'(q[0]) || c_bi !== 2'(4 - q.size()) || c_ml !== (q.size() == 1)) begin
                    bad++; $display("FAIL rnd_beat cyc%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, c_md, c_bi, c_ml, q[0], 4 - q.size(), q.size() == 1);
                end
            end
            c_sv = (cyc < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            c_sd = c_sv ? 16'($urandom) : 16'hxxxx;
            c_mr = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            exp_sr = (q.size() == 0) || (c_mr && q.size() == 1);
            total++; if (c_sr !== exp_sr) begin bad++; $display("FAIL rnd_s_ready cyc%0d got=%b exp=%b", cyc, c_sr, exp_sr); end
            if (exp_v && c_mr) void'(q.pop_front());
            if (c_sv && exp_sr) begin
                w = int'(c_sd);
                for (int k = 0; k < 4; k++) q.push_back(nib(w, k));
            end
        end
        c_sv = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_sv = 1'b1; a_sd = 16'hA55A; a_mr = 1'b1;
        @(negedge clk);
        a_sv = 1'b0;
        total++; if (a_md !== 8'h5A) begin bad++; $display("FAIL rmid_beat0 got=%h exp=5a", a_md); end
        @(negedge clk);
        total++; if (a_mv !== 1'b1 || a_md !== 8'hA5) begin bad++; $display("FAIL rmid_beat1 got=%b/%h exp=1/a5", a_mv, a_md); end
        #1 rst = 1'b1;
        #1;
        total++; if (a_mv !== 1'b0 || a_sr !== 1'b1 || a_md !== 8'h00) begin bad++; $display("FAIL rmid_async got=%b/%b/%h exp=0/1/00", a_mv, a_sr, a_md); end
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL rmid_no_resume got=%b exp=0", a_mv); end
        a_sv = 1'b1; a_sd = 16'h00FF;
        @(negedge clk);
        a_sv = 1'b0;
        total++; if (a_mv !== 1'b1 || a_md !== 8'hFF || a_ml !== 1'b0) begin bad++; $display("FAIL rmid_new0 got=%b/%h/%b exp=1/ff/0", a_mv, a_md, a_ml); end
        @(negedge clk);
        total++; if (a_mv !== 1'b1 || a_md !== 8'h00 || a_ml !== 1'b1) begin bad++; $display("FAIL rmid_new1 got=%b/%h/%b exp=1/00/1", a_mv, a_md, a_ml); end
        @(negedge clk);
        total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL rmid_drop got=%b exp=0", a_mv); end
    endtask

    task automatic test_single();
        d_mr = 1'b1; d_sv = 1'b1; d_sd = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) d_sd = 8'(i + 2);
            else d_sv = 1'b0;
            #1;
            total++; if (d_mv !== 1'b1 || d_md !== 8'(i + 1)) begin bad++; $display("FAIL single_data%0d got=%b/%h exp=1/%h", i, d_mv, d_md, i + 1); end
            total++; if (d_ml !== 1'b1 || d_bi !== 1'b0 || d_sr !== 1'b1) begin bad++; $display("FAIL single_flags%0d got=%b/%b/%b exp=1/0/1", i, d_ml, d_bi, d_sr); end
        end
        @(negedge clk);
        total++; if (d_mv !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", d_mv); end
    endtask

    initial begin
        rst  = 1'b1;
        a_sv = 1'b0; a_mr = 1'b0; a_sd = '0;
        b_sv = 1'b0; b_mr = 1'b0; b_sd = '0;
        c_sv = 1'b0; c_mr = 1'b0; c_sd = '0;
        d_sv = 1'b0; d_mr = 1'b0; d_sd = '0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
